// File: rtl/ss_wb_arb.sv
// Two-master round-robin Wishbone arbiter granting whole cyc-framed tenures.
// Optional burst preemption via forced retry is enabled by defining SS_ARB_PREEMPT_EN.
module ss_wb_arb #(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic        m0_cab,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_adr,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic        m1_cab,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_adr,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty,
  output logic        wbs_cyc,
  output logic        wbs_stb,
  output logic        wbs_we,
  output logic        wbs_cab,
  output logic [3:0]  wbs_sel,
  output logic [31:0] wbs_adr,
  input  logic        wbs_ack,
  input  logic        wbs_err,
  input  logic        wbs_rty,
  output logic [1:0]  gnt,
  output logic [1:0]  arb_err
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] arb_err_q, arb_err_d;
  logic       preempt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      arb_err_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      arb_err_q <= arb_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc && m1_cyc) state_d = last_q ? StGnt0 : StGnt1;
        else if (m0_cyc)      state_d = StGnt0;
        else if (m1_cyc)      state_d = StGnt1;
      end
      StGnt0: if (!m0_cyc) state_d = m1_cyc ? StGnt1 : StIdle;
      StGnt1: if (!m1_cyc) state_d = m0_cyc ? StGnt0 : StIdle;
      default: state_d = StIdle;
    endcase

    // Remember the most recent owner so the other master wins the next contention.
    unique case (state_d)
      StGnt0:  last_d = 1'b0;
      StGnt1:  last_d = 1'b1;
      default: last_d = last_q;
    endcase

    arb_err_d    = arb_err_q;
    arb_err_d[0] = arb_err_q[0] | (wbs_err & (state_q == StGnt0));
    arb_err_d[1] = arb_err_q[1] | (wbs_err & (state_q == StGnt1));
  end

`ifdef SS_ARB_PREEMPT_EN
  logic [7:0] beat_q, beat_d;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) beat_q <= 8'd0;
    else             beat_q <= beat_d;
  end

  always_comb begin
    beat_d = beat_q;
    if (state_d != state_q) begin
      beat_d = 8'd0;
    end else if (wbs_ack && (state_q != StIdle) && (beat_q != 8'hff)) begin
      beat_d = beat_q + 8'd1;
    end
  end

  always_comb begin
    preempt = 1'b0;
    unique case (state_q)
      StGnt0:  preempt = (beat_q >= 8'(MAX_BEATS)) && m1_cyc;
      StGnt1:  preempt = (beat_q >= 8'(MAX_BEATS)) && m0_cyc;
      default: preempt = 1'b0;
    endcase
  end
`else
  logic unused_max_beats;
  assign unused_max_beats = ^8'(MAX_BEATS);
  assign preempt          = 1'b0;
`endif

  always_comb begin
    gnt     = 2'b00;
    wbs_cyc = 1'b0;
    wbs_stb = 1'b0;
    wbs_we  = 1'b0;
    wbs_cab = 1'b0;
    wbs_sel = 4'h0;
    wbs_adr = 32'h0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m0_rty  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    m1_rty  = 1'b0;
    unique case (state_q)
      StGnt0: begin
        gnt     = 2'b01;
        wbs_cyc = m0_cyc;
        wbs_stb = m0_stb & ~preempt;
        wbs_we  = m0_we;
        wbs_cab = m0_cab;
        wbs_sel = m0_sel;
        wbs_adr = m0_adr;
        m0_ack  = wbs_ack & ~preempt;
        m0_err  = wbs_err;
        m0_rty  = wbs_rty | preempt;
      end
      StGnt1: begin
        gnt     = 2'b10;
        wbs_cyc = m1_cyc;
        wbs_stb = m1_stb & ~preempt;
        wbs_we  = m1_we;
        wbs_cab = m1_cab;
        wbs_sel = m1_sel;
        wbs_adr = m1_adr;
        m1_ack  = wbs_ack & ~preempt;
        m1_err  = wbs_err;
        m1_rty  = wbs_rty | preempt;
      end
      default: ;
    endcase
  end

  assign arb_err = arb_err_q;

endmodule

// File: tb/tb_ss_wb_arb.sv
// Bench for ss_wb_arb: bus-level master models, a responding slave, a cycle model of the
// arbitration rules and per-master beat scoreboards. Honours SS_ARB_PREEMPT_EN.
module tb_ss_wb_arb;

  localparam int MaxB = 4;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mcyc = '0, mstb = '0, mwe = '0, mcab = '0;
  logic [3:0]  msel [2];
  logic [31:0] madr [2];
  logic [1:0]  mack, merr, mrty;
  logic        wbs_cyc, wbs_stb, wbs_we, wbs_cab;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr;
  logic        wbs_ack, wbs_err, wbs_rty;
  logic [1:0]  gnt, arb_err;

  logic ack_en = 1'b1, err_en = 1'b0, rty_en = 1'b0;
  bit   rand_mode = 1'b0;
  bit   abort = 1'b0;
  int   total = 0, bad = 0;
  beat_t sbq0[$], sbq1[$];

  assign wbs_ack = wbs_cyc & wbs_stb & ack_en & ~err_en & ~rty_en;
  assign wbs_err = wbs_cyc & wbs_stb & err_en;
  assign wbs_rty = wbs_cyc & wbs_stb & rty_en & ~err_en;

  always #5 clk = ~clk;

  ss_wb_arb #(.MAX_BEATS(MaxB)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_cab(mcab[0]),
    .m0_sel(msel[0]), .m0_adr(madr[0]),
    .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_cab(mcab[1]),
    .m1_sel(msel[1]), .m1_adr(madr[1]),
    .m0_ack(mack[0]), .m0_err(merr[0]), .m0_rty(mrty[0]),
    .m1_ack(mack[1]), .m1_err(merr[1]), .m1_rty(mrty[1]),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_cab(wbs_cab),
    .wbs_sel(wbs_sel), .wbs_adr(wbs_adr),
    .wbs_ack(wbs_ack), .wbs_err(wbs_err), .wbs_rty(wbs_rty),
    .gnt(gnt), .arb_err(arb_err)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endfunction

  task automatic issue(input int id);
    beat_t b;
    mstb[id] = 1'b1;
    madr[id] = $urandom;
    msel[id] = 4'($urandom);
    b = '{adr: madr[id], sel: msel[id], we: mwe[id]};
    if (id == 0) sbq0.push_back(b);
    else         sbq1.push_back(b);
  endtask

  // One cyc-framed tenure of nb beats; ends early on retry (forced or from the slave).
  task automatic tenure(input int id, input int nb, output int done, output bit rty);
    int budget;
    done = 0;
    rty = 1'b0;
    budget = 0;
    @(posedge clk); #1;
    if (abort) return;
    mcyc[id] = 1'b1;
    mwe[id]  = 1'($urandom);
    mcab[id] = 1'($urandom);
    issue(id);
    while (done < nb) begin
      @(negedge clk);
      if (abort) return;
      if (mack[id] || merr[id]) begin
        done++;
        budget = 0;
        if (done < nb) begin
          @(posedge clk); #1;
          if (abort) return;
          issue(id);
        end
      end else if (mrty[id]) begin
        rty = 1'b1;
        if (id == 0) void'(sbq0.pop_back());
        else         void'(sbq1.pop_back());
        break;
      end else if (++budget > 400) begin
        chk($sformatf("timeout_m%0d", id), 64'(budget), 64'd400);
        break;
      end
    end
    @(posedge clk); #1;
    if (!abort) begin
      mcyc[id] = 1'b0;
      mstb[id] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    abort = 1'b1;
    mcyc  = '0;
    mstb  = '0;
    sbq0.delete();
    sbq1.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    abort = 1'b0;
  endtask

  task automatic rand_master(input int id);
    int d;
    bit r;
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      tenure(id, $urandom_range(1, 6), d, r);
    end
  endtask

  initial begin : slave_drv
    forever begin
      @(posedge clk); #1;
      if (rand_mode) begin
        ack_en = ($urandom % 10) < 7;
        err_en = ($urandom % 25) == 0;
        rty_en = ($urandom % 25) == 0;
      end
    end
  end

  // Cycle model: grant from last cycle's requests by the arbitration rules, plus scoreboards.
  initial begin : monitor
    int pg, g, lastsv, beats;
    bit [1:0] pr, eg, arb;
    bit pre;
    beat_t b;
    pg = -1; pr = '0; lastsv = 1; beats = 0; arb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pg = -1; pr = '0; lastsv = 1; beats = 0; arb = '0;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_wbs_cyc", 64'(wbs_cyc), 64'd0);
        chk("rst_arb_err", 64'(arb_err), 64'd0);
        chk("rst_resp", 64'({mack, merr, mrty}), 64'd0);
      end else begin
        if (pg >= 0 && pr[pg])            g = pg;
        else if (pg >= 0)                 g = pr[1-pg] ? 1 - pg : -1;
        else if (pr == 2'b11)             g = (lastsv == 0) ? 1 : 0;
        else if (pr[0])                   g = 0;
        else if (pr[1])                   g = 1;
        else                              g = -1;
        if (g != pg) beats = 0;
        if (g >= 0) lastsv = g;
        pre = 1'b0;
`ifdef SS_ARB_PREEMPT_EN
        pre = (g >= 0) && (beats >= MaxB) && mcyc[1-g];
`endif
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("arb_err", 64'(arb_err), 64'(arb));
        chk("wbs_cyc", 64'(wbs_cyc), (g < 0) ? 64'd0 : 64'(mcyc[g]));
        chk("wbs_stb", 64'(wbs_stb), (g < 0 || pre) ? 64'd0 : 64'(mstb[g]));
        chk("wbs_we", 64'(wbs_we), (g < 0) ? 64'd0 : 64'(mwe[g]));
        chk("wbs_cab", 64'(wbs_cab), (g < 0) ? 64'd0 : 64'(mcab[g]));
        chk("wbs_sel", 64'(wbs_sel), (g < 0) ? 64'd0 : 64'(msel[g]));
        chk("wbs_adr", 64'(wbs_adr), (g < 0) ? 64'd0 : 64'(madr[g]));
        for (int n = 0; n < 2; n++) begin
          chk($sformatf("m%0d_ack", n), 64'(mack[n]), 64'((g == n) && wbs_ack && !pre));
          chk($sformatf("m%0d_err", n), 64'(merr[n]), 64'((g == n) && wbs_err));
          chk($sformatf("m%0d_rty", n), 64'(mrty[n]), 64'((g == n) && (wbs_rty || pre)));
          if (mack[n] || merr[n]) begin
            if ((n == 0 && sbq0.size() == 0) || (n == 1 && sbq1.size() == 0)) begin
              chk($sformatf("sb_m%0d_empty", n), 64'd1, 64'd0);
            end else begin
              b = (n == 0) ? sbq0.pop_front() : sbq1.pop_front();
              chk($sformatf("sb_m%0d_beat", n), 64'({wbs_adr, wbs_sel, wbs_we}), 64'(b));
            end
          end
        end
        if (g >= 0 && wbs_err) arb[g] = 1'b1;
        if (g >= 0 && wbs_ack) beats++;
        pg = g;
        pr = mcyc;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, d1;
    bit r0, r1;
    msel[0] = '0; msel[1] = '0; madr[0] = '0; madr[1] = '0;
    do_reset();

    // Single request from idle: grant one cycle after cyc rises.
    fork
      tenure(0, 3, d0, r0);
      begin
        @(posedge clk); @(negedge clk);
        chk("t1_gnt_wait", 64'(gnt), 64'd0);
        @(negedge clk);
        chk("t1_gnt", 64'(gnt), 64'd1);
        chk("t1_adr", 64'(wbs_adr), 64'(madr[0]));
      end
    join
    chk("t1_beats", 64'(d0), 64'd3);

    // Contention after reset: m0 first, then m1, then m0 again.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      fork
        tenure(0, 2, d0, r0);
        tenure(1, 2, d1, r1);
        begin
          @(posedge clk); @(negedge clk); @(negedge clk);
          chk("t2_first_gnt", 64'(gnt), 64'd1);
        end
      join
      chk("t2_beats", 64'({d0[7:0], d1[7:0]}), 64'h0202);
    end

    // Error on m1 tenure is sticky on arb_err[1] only.
    err_en = 1'b1;
    tenure(1, 2, d1, r1);
    err_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_arb_err", 64'(arb_err), 64'd2);

    // Long m1 burst while m0 waits.
    fork
      tenure(1, 10, d1, r1);
      begin @(posedge clk); tenure(0, 2, d0, r0); end
    join
`ifdef SS_ARB_PREEMPT_EN
    chk("t4_m1_beats", 64'(d1), 64'(MaxB));
    chk("t4_m1_rty", 64'(r1), 64'd1);
`else
    chk("t4_m1_beats", 64'(d1), 64'd10);
    chk("t4_m1_rty", 64'(r1), 64'd0);
`endif
    chk("t4_m0_beats", 64'(d0), 64'd2);

    // Reset mid-burst drops the bus without a clock edge.
    fork
      tenure(0, 50, d0, r0);
      begin
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        abort = 1'b1;
        mcyc  = '0;
        mstb  = '0;
        sbq0.delete();
        sbq1.delete();
        #1;
        chk("t5_wbs_cyc", 64'(wbs_cyc), 64'd0);
        chk("t5_gnt", 64'(gnt), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        abort = 1'b0;
      end
    join
    @(negedge clk);
    chk("t5_gnt_after", 64'(gnt), 64'd0);

    // Random concurrent traffic with random slave responses.
    rand_mode = 1'b1;
    fork
      rand_master(0);
      rand_master(1);
    join
    rand_mode = 1'b0;
    ack_en = 1'b1; err_en = 1'b0; rty_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sbq0.size() + sbq1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ss_wb_arb.md
# ss_wb_arb

Two-master Wishbone arbiter that shares the single system-bus master port between the source (read, RW=0) and destination (write, RW=1) scatter-gather engines of the ADMA copy channel. It grants whole Wishbone cycles (cyc-framed tenures) round-robin, muxes the granted engine onto the bus, and routes ack/err/rty back to it. Optionally it preempts long bursts with a forced retry so the other engine is not starved.

## Interface
Parameters:
- MAX_BEATS, 16: ack count per tenure after which preemption may occur (only with SS_ARB_PREEMPT_EN); legal range 4..255.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low.
- m0_cyc, m0_stb, m0_we, m0_cab  in  1 each  source engine request.
- m0_sel  in  4  source engine byte select.
- m0_adr  in  32  source engine address.
- m1_cyc, m1_stb, m1_we, m1_cab  in  1 each  destination engine request.
- m1_sel  in  4  destination engine byte select.
- m1_adr  in  32  destination engine address.
- m0_ack, m0_err, m0_rty  out  1 each  responses to source engine.
- m1_ack, m1_err, m1_rty  out  1 each  responses to destination engine.
- wbs_cyc, wbs_stb, wbs_we, wbs_cab  out  1 each  bus request.
- wbs_sel  out  4  bus byte select.
- wbs_adr  out  32  bus address.
- wbs_ack, wbs_err, wbs_rty  in  1 each  bus responses.
- gnt  out  2  one-hot grant {m1, m0}; used by the data-path mux.
- arb_err  out  2  sticky per-master error flag {m1, m0}.

## Operation
- States: S_IDLE, S_GNT0, S_GNT1 (registered).
- Round-robin pointer `last` (1 bit), reset to 1 so m0 wins the first contention.
- S_IDLE: if exactly one mN_cyc is high, go to S_GNTN. If both are high, grant the master != `last`. Otherwise stay.
- S_GNTN: set `last` = N on entry. When mN_cyc is low, go to S_GNT(other) if the other cyc is high, else go to S_IDLE.
- Pass-through: while in S_GNTN, wbs_{cyc,stb,we,cab,sel,adr} equal mN_*. This is combinational from the state register.
- Non-granted and idle outputs: in S_IDLE all wbs_* are 0.
- Response routing: mN_ack/err/rty = wbs_ack/err/rty & (state==S_GNTN). The non-granted master sees all zeros.
- Read data (wbs_dat_o/dat64_o) is broadcast by the top level. Masters qualify it with their own ack.
- Beat counter: 8 bits, saturating. Clears on any grant change. Increments on wbs_ack in S_GNT0/S_GNT1.
- Error flag: wbs_err while granted to N sets arb_err[N]. It is cleared only by reset.

## Timing
- Grant latency: mN_cyc first high in cycle t (arbiter idle) → state=S_GNTN and wbs_cyc high in cycle t+1.
- Release: the engine drops cyc the cycle after its final ack (cycle t) → arbiter sees cyc low in t+1 and changes state at the t+2 edge. There are no dead cycles between back-to-back tenures beyond this.
- Simultaneous release by one master and request by the other: the handoff goes directly S_GNTN→S_GNT(other), with no S_IDLE.
- ack/err/rty are forwarded in the same cycle (zero latency).
- Reset values:
  - state=S_IDLE, last=1, gnt=2'b00, arb_err=2'b00, beat counter=0.
  - All wbs_* outputs are 0 and all mN_ack/err/rty are 0.
- Reset asserted mid-tenure: wbs_cyc drops asynchronously. The engine's transfer is abandoned and the engines must also be reset.
- A master raising cyc while the other holds the grant waits; it is never dropped.

## Configuration
- SS_ARB_PREEMPT_EN defined:
  - In S_GNTN, when the beat count ≥ MAX_BEATS and the other mcyc is high, the arbiter forces wbs_stb=0 and drives mN_rty=1 (mN_ack=0) every cycle until mN_cyc falls. It then hands off to the other master.
  - Descriptor fetches (2 beats) are never preempted because MAX_BEATS ≥ 4.
- SS_ARB_PREEMPT_EN undefined:
  - No forced retry; a tenure lasts until the master drops cyc.
  - MAX_BEATS is unused and the beat counter may be removed.

## Test plan
- Reset, then m0_cyc high at cycle 3 → gnt=01 and wbs_cyc=1 at cycle 4, wbs_adr=m0_adr; m1_ack stays 0 throughout.
- Both cyc high in the same cycle after reset → m0 is granted first. m0 drops cyc → gnt=10 two cycles after m0's last ack. On the next contention → m0 is granted again (alternation).
- wbs_err during an m1 tenure → m1_err=1 in the same cycle and arb_err=2'b10 sticky. m0 is unaffected.
- With SS_ARB_PREEMPT_EN and MAX_BEATS=4: m1 bursts 10 beats while m0_cyc is held high → after the 4th ack, m1_rty=1 and wbs_stb=0 until m1_cyc falls, then gnt=01.
- Same stimulus without SS_ARB_PREEMPT_EN → all 10 m1 beats complete uninterrupted, with no rty.
- Assert wb_rst_n_i=0 mid-burst → wbs_cyc=0 and gnt=00 immediately (no clock edge required), and state=S_IDLE after release.
